vreg_file_param: RTL
====================

Name: vreg_file_param

Overview:
Parametrised vector register file for the vector datapath. It is the successor to the fixed 512-bit file. It adds configurable vector length, element width and register count, per-element write masking, a valid/ready load/store port, write-first bypass, and a hardware zero-initialisation sequencer after reset. It sits between the vector ALU (two read ports, one masked write port) and the memory interface (load/store port).

Parameters:
VLEN, 512, bits per vector register; must be a multiple of ELEN.
ELEN, 32, element (lane) width in bits; LANES = VLEN/ELEN (derived, 16 at defaults).
NREGS, 8, number of vector registers; power of two, at least 2; AW = clog2(NREGS) (derived).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
rd_en  in  1  read strobe for both read ports.
rd1_addr  in  AW  read port 1 register index.
rd2_addr  in  AW  read port 2 register index.
rd1_data  out  VLEN  registered read data, port 1.
rd2_data  out  VLEN  registered read data, port 2.
wr_en  in  1  ALU write strobe.
wr_addr  in  AW  ALU write register index.
wr_data  in  VLEN  ALU write data.
wr_mask  in  LANES  per-lane write enable; bit i controls bits [i*ELEN +: ELEN].
ld_valid  in  1  load request.
ld_ready  out  1  load accepted when ld_valid and ld_ready are both high.
ld_addr  in  AW  load destination register.
ld_data  in  VLEN  load data; full, unmasked register write.
st_valid  in  1  store request.
st_ready  out  1  store accepted when st_valid and st_ready are both high.
st_addr  in  AW  store source register.
st_data  out  VLEN  store data.
st_data_valid  out  1  one-cycle pulse marking st_data valid.
init_busy  out  1  high while the zero-initialisation sequencer runs.

Behaviour:
- FSM states INIT and RUN. Reset high at any edge forces INIT and clears the init index to 0. This also applies when reset arrives mid-INIT or mid-operation.
- Reset values: rd1_data = 0, rd2_data = 0, st_data = 0, st_data_valid = 0, ld_ready = 0, st_ready = 0, init_busy = 1.
- INIT: each cycle the sequencer writes 0 to register[idx] and increments idx. The cycle it writes idx = NREGS-1, the FSM moves to RUN. INIT therefore lasts exactly NREGS cycles after reset deasserts.
- During INIT, init_busy = 1, ld_ready = st_ready = 0, and rd_en and wr_en are ignored. Outputs hold their reset values.
- RUN: init_busy = 0, ld_ready = 1, st_ready = 1. RUN is stable until the next reset.
- Masked write: when wr_en is high, each lane i with wr_mask[i] = 1 takes wr_data's lane; unmasked lanes keep their value. wr_mask = 0 is a legal no-op.
- Load: an accepted load writes ld_data to register[ld_addr] in full.
- Collision: if an accepted load and wr_en target the same address in the same cycle, the load wins and the entire wr_en write is discarded. Different addresses both commit in the same cycle.
- Read: with rd_en high, rd1_data and rd2_data update at the edge, giving 1-cycle latency. With rd_en low, both outputs hold their previous values.
- Write-first bypass: a read or store that addresses a register written in the same cycle returns the post-write value, after masking and collision priority are applied.
- Store: an accepted store loads st_data with register[st_addr] (bypass applies) and raises st_data_valid for exactly one cycle. Back-to-back stores are accepted every cycle. st_data holds its value between stores.
- rd1_addr may equal rd2_addr; both ports then return the same value.

Test Plan:
- Defaults (512/32/8): reset for 1 cycle -> init_busy = 1 and ld_ready = 0 for exactly 8 cycles, then 1; reading r0..r7 -> all 0.
- Load r2 = {16{32'hA5A5A5A5}}, then rd_en with rd1_addr = 2 -> rd1_data = that pattern one cycle later.
- wr_en to r2 with wr_data all ones and wr_mask = 16'h00FF -> lanes 0-7 = FFFFFFFF, lanes 8-15 = A5A5A5A5.
- Same cycle: load r3 = {16{32'h11111111}} and wr_en r3 = {16{32'h22222222}} with mask FFFF -> r3 = all 11111111. Repeat with wr_addr = 4 -> r3 = 1111..., r4 = 2222....
- wr_en r5 = {16{32'hDEADBEEF}}, mask FFFF, with rd_en rd2_addr = 5 and st_valid st_addr = 5 in the same cycle -> next cycle rd2_data = st_data = DEADBEEF pattern, and st_data_valid high for exactly 1 cycle.
- Reset asserted mid-RUN after the writes above -> INIT repeats for 8 cycles; r2, r3 and r5 then read 0.

Source files
------------

// File: rtl/vreg_file_param.sv
// Parametrised vector register file: two registered read ports, one lane-masked ALU
// write port, a valid/ready load/store port, write-first bypass and a post-reset zero-init sequencer.
module vreg_file_param #(
    parameter int VLEN  = 512,
    parameter int ELEN  = 32,
    parameter int NREGS = 8,
    localparam int LANES = VLEN / ELEN,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd1_addr,
    input  logic [AW-1:0]    rd2_addr,
    output logic [VLEN-1:0]  rd1_data,
    output logic [VLEN-1:0]  rd2_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VLEN-1:0]  wr_data,
    input  logic [LANES-1:0] wr_mask,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [VLEN-1:0]  ld_data,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [AW-1:0]    st_addr,
    output logic [VLEN-1:0]  st_data,
    output logic             st_data_valid,
    output logic             init_busy
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   init_idx, init_idx_next;
    logic [VLEN-1:0] mem [NREGS];

    logic            running;
    logic            ld_acc, st_acc, wr_act;
    logic [VLEN-1:0] wr_merged;
    logic [VLEN-1:0] rd1_byp, rd2_byp, st_byp;

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_next    = state;
        init_idx_next = init_idx;
        if (state == INIT) begin
            init_idx_next = init_idx + 1'b1;
            if (init_idx == AW'(NREGS - 1))
                state_next = RUN;
        end
    end

    assign running   = (state == RUN);
    assign init_busy = (state == INIT);
    assign ld_ready  = running;
    assign st_ready  = running;

    // ---------------- write resolution ----------------
    assign ld_acc = ld_valid && running;
    assign st_acc = st_valid && running;
    // A load to the same register discards the whole ALU write.
    assign wr_act = wr_en && running && !(ld_acc && (ld_addr == wr_addr));

    always_comb begin
        wr_merged = mem[wr_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_mask[i])
                wr_merged[i*ELEN +: ELEN] = wr_data[i*ELEN +: ELEN];
        end
    end

    function automatic logic [VLEN-1:0] post_write(
        input logic [AW-1:0]   addr,
        input logic [VLEN-1:0] cur,
        input logic            ld_hit_en,
        input logic [AW-1:0]   ld_a,
        input logic [VLEN-1:0] ld_d,
        input logic            wr_hit_en,
        input logic [AW-1:0]   wr_a,
        input logic [VLEN-1:0] wr_d
    );
        if (ld_hit_en && (ld_a == addr))
            return ld_d;
        else if (wr_hit_en && (wr_a == addr))
            return wr_d;
        else
            return cur;
    endfunction

    always_comb begin
        rd1_byp = post_write(rd1_addr, mem[rd1_addr], ld_acc, ld_addr, ld_data, wr_act, wr_addr, wr_merged);
        rd2_byp = post_write(rd2_addr, mem[rd2_addr], ld_acc, ld_addr, ld_data, wr_act, wr_addr, wr_merged);
        st_byp  = post_write(st_addr,  mem[st_addr],  ld_acc, ld_addr, ld_data, wr_act, wr_addr, wr_merged);
    end

    // ---------------- storage ----------------
    // NOTE: the array has no reset branch; the INIT sequencer clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[init_idx] <= '0;
            end else begin
                if (wr_act)
                    mem[wr_addr] <= wr_merged;
                if (ld_acc)
                    mem[ld_addr] <= ld_data;
            end
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_data      <= '0;
            rd2_data      <= '0;
            st_data       <= '0;
            st_data_valid <= 1'b0;
        end else begin
            st_data_valid <= st_acc;
            if (rd_en && running) begin
                rd1_data <= rd1_byp;
                rd2_data <= rd2_byp;
            end
            if (st_acc)
                st_data <= st_byp;
        end
    end

endmodule
